// File: rtl/vector_apu_queue.sv
// vector_apu_queue: DEPTH-entry in-order FIFO between the core APU handshake and vector_decoder
//   clk, n_reset                      clock, async active-low reset
//   core_apu_req/gnt/operands/op/flags_i  core-side request handshake and payload
//   core_apu_rvalid/result            registered result returned to the core
//   dec_apu_req/gnt/operands/op/flags head-of-queue handshake and payload to the decoder
//   dec_apu_rvalid/result             completion from the decoder
//   occupancy, in_flight, busy        queue fill, accepted-but-unanswered count, in_flight != 0
//   protocol_error                    sticky: result with nothing in flight, or push at saturation
module vector_apu_queue #(
   parameter int DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             n_reset,
   input  logic                             core_apu_req,
   output logic                             core_apu_gnt,
   input  logic [2:0][31:0]                 core_apu_operands,
   input  logic [5:0]                       core_apu_op,
   input  logic [14:0]                      core_apu_flags_i,
   output logic                             core_apu_rvalid,
   output logic [31:0]                      core_apu_result,
   output logic                             dec_apu_req,
   input  logic                             dec_apu_gnt,
   output logic [2:0][31:0]                 dec_apu_operands,
   output logic [5:0]                       dec_apu_op,
   output logic [14:0]                      dec_apu_flags,
   input  logic                             dec_apu_rvalid,
   input  logic [31:0]                      dec_apu_result,
   output logic [$clog2(DEPTH):0]           occupancy,
   output logic [$clog2(DEPTH+2)-1:0]       in_flight,
   output logic                             busy,
   output logic                             protocol_error
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(DEPTH + 2);
   localparam int EW = 96 + 6 + 15;
   localparam logic [AW:0] OCC_FULL = (AW + 1)'(DEPTH);
   localparam logic [FW-1:0] FL_MAX = FW'(DEPTH + 1);
   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] last_q, head;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   occ_q, occ_d;
   logic [FW-1:0] fl_q, fl_d;
   logic          full, empty, push, pop, both, inc, dec, err_q, err_d, rvalid_q;
   logic [31:0]   result_q;
   assign full  = occ_q == OCC_FULL;
   assign empty = occ_q == '0;
   assign push  = core_apu_req & ~full;
   assign pop   = dec_apu_gnt & ~empty;
   // When empty the head slot may be stale, so the last popped entry is shown instead.
   assign head  = empty ? last_q : mem_q[rd_ptr_q];
   assign {dec_apu_flags, dec_apu_op, dec_apu_operands} = head;
   // A push and a legitimate completion cancel; either alone is clipped at the count limits.
   assign both  = push & dec_apu_rvalid & (fl_q != '0);
   assign inc   = push & ~both & (fl_q != FL_MAX);
   assign dec   = dec_apu_rvalid & ~both & (fl_q != '0);
   assign occ_d = occ_q + (AW + 1)'(push) - (AW + 1)'(pop);
   assign fl_d  = fl_q + FW'(inc) - FW'(dec);
   assign err_d = err_q | (dec_apu_rvalid & (fl_q == '0)) | (push & ~both & (fl_q == FL_MAX));
   assign core_apu_gnt    = ~full;
   assign dec_apu_req     = ~empty;
   assign core_apu_rvalid = rvalid_q;
   assign core_apu_result = result_q;
   assign occupancy       = occ_q;
   assign in_flight       = fl_q;
   assign busy            = fl_q != '0;
   assign protocol_error  = err_q;
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {core_apu_flags_i, core_apu_op, core_apu_operands};
   end
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         fl_q     <= '0;
         err_q    <= 1'b0;
         rvalid_q <= 1'b0;
         result_q <= '0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + AW'(push);
         rd_ptr_q <= rd_ptr_q + AW'(pop);
         occ_q    <= occ_d;
         fl_q     <= fl_d;
         err_q    <= err_d;
         rvalid_q <= dec_apu_rvalid;
         if (dec_apu_rvalid) result_q <= dec_apu_result;
         if (pop) last_q <= mem_q[rd_ptr_q];
      end
   end
endmodule

// File: tb/tb_vector_apu_queue.sv
// tb_vector_apu_queue: directed self-checking bench for vector_apu_queue at DEPTH=4
module tb_vector_apu_queue;
   localparam int DEPTH = 4;
   logic            clk = 1'b0, n_reset = 1'b0;
   logic            core_apu_req = 1'b0, core_apu_gnt;
   logic [2:0][31:0] core_apu_operands = '0;
   logic [5:0]      core_apu_op = '0;
   logic [14:0]     core_apu_flags_i = '0;
   logic            core_apu_rvalid;
   logic [31:0]     core_apu_result;
   logic            dec_apu_req, dec_apu_gnt = 1'b0;
   logic [2:0][31:0] dec_apu_operands;
   logic [5:0]      dec_apu_op;
   logic [14:0]     dec_apu_flags;
   logic            dec_apu_rvalid = 1'b0;
   logic [31:0]     dec_apu_result = '0;
   logic [2:0]      occupancy;
   logic [2:0]      in_flight;
   logic            busy, protocol_error;
   int              n_tests = 0, n_fail = 0;

   vector_apu_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .n_reset(n_reset),
      .core_apu_req(core_apu_req), .core_apu_gnt(core_apu_gnt),
      .core_apu_operands(core_apu_operands), .core_apu_op(core_apu_op),
      .core_apu_flags_i(core_apu_flags_i),
      .core_apu_rvalid(core_apu_rvalid), .core_apu_result(core_apu_result),
      .dec_apu_req(dec_apu_req), .dec_apu_gnt(dec_apu_gnt),
      .dec_apu_operands(dec_apu_operands), .dec_apu_op(dec_apu_op),
      .dec_apu_flags(dec_apu_flags),
      .dec_apu_rvalid(dec_apu_rvalid), .dec_apu_result(dec_apu_result),
      .occupancy(occupancy), .in_flight(in_flight), .busy(busy),
      .protocol_error(protocol_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      check("rst_occ", 32'(occupancy), 0);
      check("rst_inflight", 32'(in_flight), 0);
      check("rst_dec_req", 32'(dec_apu_req), 0);
      check("rst_gnt", 32'(core_apu_gnt), 1);
      check("rst_rvalid", 32'(core_apu_rvalid), 0);
      check("rst_result", core_apu_result, 0);
      check("rst_perr", 32'(protocol_error), 0);
      @(negedge clk);
      n_reset = 1'b1;
      tick();

      // single instruction round trip
      core_apu_req = 1'b1;
      core_apu_operands = '{32'h3, 32'h2, 32'h57};
      core_apu_op = 6'h08;
      core_apu_flags_i = 15'h1234;
      check("t1_no_bypass", 32'(dec_apu_req), 0);
      tick();
      core_apu_req = 1'b0;
      check("t1_dec_req", 32'(dec_apu_req), 1);
      check("t1_instr", dec_apu_operands[0], 32'h57);
      check("t1_opnd2", dec_apu_operands[2], 32'h3);
      check("t1_op", 32'(dec_apu_op), 32'h08);
      check("t1_flags", 32'(dec_apu_flags), 32'h1234);
      check("t1_inflight1", 32'(in_flight), 1);
      dec_apu_gnt = 1'b1;
      tick();
      dec_apu_gnt = 1'b0;
      check("t1_popped", 32'(dec_apu_req), 0);
      check("t1_hold_payload", 32'(dec_apu_op), 32'h08);
      check("t1_busy", 32'(busy), 1);
      dec_apu_rvalid = 1'b1;
      dec_apu_result = 32'h11;
      tick();
      dec_apu_rvalid = 1'b0;
      check("t1_rvalid", 32'(core_apu_rvalid), 1);
      check("t1_result", core_apu_result, 32'h11);
      check("t1_inflight0", 32'(in_flight), 0);
      tick();
      check("t1_rvalid_pulse", 32'(core_apu_rvalid), 0);
      check("t1_result_hold", core_apu_result, 32'h11);

      // fill to full, fifth accepted only after a pop
      for (int i = 0; i < 5; i++) begin
         core_apu_req = 1'b1;
         core_apu_operands[0] = 32'h100 + 32'(i);
         check("t2_gnt", 32'(core_apu_gnt), (i < 4) ? 1 : 0);
         tick();
      end
      check("t2_occ_full", 32'(occupancy), 4);
      check("t2_inflight4", 32'(in_flight), 4);
      dec_apu_gnt = 1'b1;
      check("t2_no_passthru", 32'(core_apu_gnt), 0);
      tick();
      dec_apu_gnt = 1'b0;
      check("t2_occ3", 32'(occupancy), 3);
      check("t2_gnt_back", 32'(core_apu_gnt), 1);
      tick();
      core_apu_req = 1'b0;
      check("t2_fifth_in", 32'(occupancy), 4);
      check("t2_inflight5", 32'(in_flight), 5);
      dec_apu_gnt = 1'b1;
      for (int j = 0; j < 4; j++) begin
         check("t2_order", dec_apu_operands[0], 32'h101 + 32'(j));
         tick();
      end
      dec_apu_gnt = 1'b0;
      check("t2_drained", 32'(occupancy), 0);
      dec_apu_rvalid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         dec_apu_result = 32'h200 + 32'(k);
         tick();
         check("t2_res", core_apu_result, 32'h200 + 32'(k));
      end
      dec_apu_rvalid = 1'b0;
      check("t2_inflight0", 32'(in_flight), 0);
      check("t2_perr", 32'(protocol_error), 0);

      // streaming push+pop with results returned each cycle
      core_apu_req = 1'b1;
      core_apu_operands[0] = 32'd1;
      tick();
      for (int i = 2; i <= 10; i++) begin
         core_apu_operands[0] = 32'(i);
         dec_apu_gnt = 1'b1;
         dec_apu_rvalid = 1'b1;
         dec_apu_result = 32'h300 + 32'(i);
         check("t3_head", dec_apu_operands[0], 32'(i - 1));
         check("t3_occ", 32'(occupancy), 1);
         check("t3_inflight", 32'(in_flight), 1);
         tick();
         check("t3_res", core_apu_result, 32'h300 + 32'(i));
      end
      core_apu_req = 1'b0;
      dec_apu_result = 32'h3ff;
      check("t3_last", dec_apu_operands[0], 32'd10);
      tick();
      dec_apu_gnt = 1'b0;
      dec_apu_rvalid = 1'b0;
      check("t3_empty", 32'(occupancy), 0);
      check("t3_inflight0", 32'(in_flight), 0);
      check("t3_perr", 32'(protocol_error), 0);

      // stray result
      dec_apu_rvalid = 1'b1;
      dec_apu_result = 32'h33;
      tick();
      dec_apu_rvalid = 1'b0;
      check("t4_perr", 32'(protocol_error), 1);
      check("t4_rvalid", 32'(core_apu_rvalid), 1);
      check("t4_result", core_apu_result, 32'h33);
      check("t4_inflight", 32'(in_flight), 0);
      tick();
      check("t4_sticky", 32'(protocol_error), 1);

      // simultaneous push and completion
      core_apu_req = 1'b1;
      tick();
      tick();
      check("t6_pre", 32'(in_flight), 2);
      dec_apu_rvalid = 1'b1;
      dec_apu_result = 32'h44;
      check("t6_no_early_rvalid", 32'(core_apu_rvalid), 0);
      tick();
      core_apu_req = 1'b0;
      dec_apu_rvalid = 1'b0;
      check("t6_inflight", 32'(in_flight), 2);
      check("t6_rvalid", 32'(core_apu_rvalid), 1);
      check("t6_result", core_apu_result, 32'h44);
      check("t6_occ", 32'(occupancy), 3);

      // reset mid-operation
      dec_apu_gnt = 1'b1;
      tick();
      dec_apu_gnt = 1'b0;
      core_apu_req = 1'b1;
      tick();
      core_apu_req = 1'b0;
      check("t5_pre_occ", 32'(occupancy), 3);
      #2;
      n_reset = 1'b0;
      dec_apu_rvalid = 1'b1;
      #1;
      check("t5_occ", 32'(occupancy), 0);
      check("t5_inflight", 32'(in_flight), 0);
      check("t5_dec_req", 32'(dec_apu_req), 0);
      check("t5_gnt", 32'(core_apu_gnt), 1);
      check("t5_perr", 32'(protocol_error), 0);
      tick();
      dec_apu_rvalid = 1'b0;
      n_reset = 1'b1;
      tick();
      check("t5_no_rvalid", 32'(core_apu_rvalid), 0);
      check("t5_occ_after", 32'(occupancy), 0);

      // in_flight saturation at DEPTH+1
      core_apu_req = 1'b1;
      repeat (4) tick();
      dec_apu_gnt = 1'b1;
      tick();
      dec_apu_gnt = 1'b0;
      tick();
      check("sat_max", 32'(in_flight), 5);
      check("sat_no_err", 32'(protocol_error), 0);
      dec_apu_gnt = 1'b1;
      tick();
      dec_apu_gnt = 1'b0;
      tick();
      core_apu_req = 1'b0;
      check("sat_hold", 32'(in_flight), 5);
      check("sat_err", 32'(protocol_error), 1);
      check("sat_occ", 32'(occupancy), 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
